cam_capture_window: RTL and testbench
=====================================

CAM_CAPTURE_WINDOW -- requirements
Module: cam_capture_window

Interface
REQ-001 SHALL have parameter PIX_BYTES, default 2, bytes per pixel (1 or 2).
REQ-002 SHALL have parameter FRAME_W, default 640, pixels per source line.
REQ-003 SHALL have parameter FRAME_H, default 480, lines per source frame.
REQ-004 SHALL have parameter DECIM, default 1, decimation factor in both axes (1, 2 or 4).
REQ-005 SHALL have parameter FCNT_W, default 16, frame counter width.
REQ-006 SHALL have port p_clk  in  1  pixel clock; the only clock; all logic on its rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports capture_en  in  1  (arm capture) and byte_swap  in  1  (low byte first when 1).
REQ-009 SHALL have ports vsync, href  in  1 each, and p_data  in  8, the camera bus.
REQ-010 SHALL have port pixel_data  out  8*PIX_BYTES  assembled pixel.
REQ-011 SHALL have port pixel_valid  out  1  one-cycle qualifier for pixel_data, pixel_x and pixel_y.
REQ-012 SHALL have ports pixel_x  out  clog2(FRAME_W/DECIM) and pixel_y  out  clog2(FRAME_H/DECIM), output coordinates.
REQ-013 SHALL have ports frame_start and frame_done  out  1 each, one-cycle pulses.
REQ-014 SHALL have ports frame_count  out  FCNT_W (completed frames) and line_err  out  1 (sticky error).

Function
REQ-015 SHALL register vsync and href once; all edge detection SHALL use the current versus the registered sample.
REQ-016 SHALL implement states IDLE, WAIT_VS, ACTIVE.
REQ-017 IDLE -> WAIT_VS when capture_en=1; WAIT_VS -> ACTIVE on a vsync falling edge, with frame_start pulsed that cycle.
REQ-018 ACTIVE -> WAIT_VS on a vsync rising edge when capture_en=1, else -> IDLE; frame_done pulses on that edge only if at least one href line was received.
REQ-019 Capture_en deassertion mid-frame SHALL NOT abort the frame; the frame completes first.
REQ-020 In ACTIVE with href=1, each p_data byte SHALL be captured; for PIX_BYTES=2 the first byte is bits [15:8] (bits [7:0] when byte_swap=1).
REQ-021 pixel_valid SHALL assert exactly one cycle after the final byte of a pixel is sampled (latency 1).
REQ-022 Source column count SHALL clear on href rising edge; source row SHALL clear at frame_start and increment on each href falling edge.
REQ-023 A pixel SHALL be emitted only when source column mod DECIM = 0 and source row mod DECIM = 0; pixel_x and pixel_y SHALL equal the source column and row divided by DECIM.
REQ-024 Pixels beyond column FRAME_W-1 or row FRAME_H-1 SHALL be dropped, and counters SHALL saturate without wrapping.
REQ-025 A partial pixel (odd byte count) at href fall SHALL be discarded.
REQ-026 frame_count SHALL increment with each frame_done and wrap modulo 2^FCNT_W.
REQ-027 An href rising edge in WAIT_VS or IDLE SHALL be ignored.

Reset
REQ-028 Reset SHALL force state IDLE and zero pixel_data, pixel_valid, pixel_x, pixel_y, frame_start, frame_done, frame_count, line_err, and all internal counters.
REQ-029 Reset mid-frame SHALL discard the frame; capture SHALL resume only after the next vsync falling edge.

Configuration
REQ-030 With macro CAM_LINE_CHECK_EN defined, each completed line's byte count SHALL be compared with FRAME_W*PIX_BYTES, and any mismatch (including a partial pixel) SHALL set line_err until reset.
REQ-031 Without CAM_LINE_CHECK_EN, line_err SHALL be constant 0 and no check logic is synthesised.

Verification
REQ-032 PIX_BYTES=2: after vsync fall, href line bytes 0xAB,0xCD -> pixel_valid one cycle after 0xCD, pixel_data=0xABCD, x=0, y=0; with byte_swap=1 -> 0xCDAB.
REQ-033 FRAME_W=8, FRAME_H=4, DECIM=2: full frame -> 8 pixel_valid pulses, x in 0..3, y in 0..1, then frame_done and frame_count=1.
REQ-034 capture_en dropped during line 2 -> frame completes, frame_done pulses, state IDLE; the next frame produces no pixels.
REQ-035 reset asserted mid-line -> outputs 0 the next cycle; remaining href bytes produce no pixel_valid until after a new vsync fall.
REQ-036 CAM_LINE_CHECK_EN, FRAME_W=8: a line of 15 bytes -> line_err=1 and stays set; without the macro -> line_err=0.
REQ-037 FCNT_W=2: 5 frames -> frame_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/cam_capture_window.sv
// cam_capture_window: captures pixels from a parallel camera bus (vsync/href/p_data).
// Decimates by DECIM in both axes, crops to FRAME_W x FRAME_H, and counts completed frames.
// Optional build macro CAM_LINE_CHECK_EN: checks each line's byte count and sets a sticky line_err.
module cam_capture_window #(
    parameter int PIX_BYTES = 2,
    parameter int FRAME_W   = 640,
    parameter int FRAME_H   = 480,
    parameter int DECIM     = 1,
    parameter int FCNT_W    = 16
) (
    input  logic                                p_clk,
    input  logic                                reset,
    input  logic                                capture_en,
    input  logic                                byte_swap,
    input  logic                                vsync,
    input  logic                                href,
    input  logic [7:0]                          p_data,
    output logic [8*PIX_BYTES-1:0]              pixel_data,
    output logic                                pixel_valid,
    output logic [$clog2(FRAME_W/DECIM)-1:0]    pixel_x,
    output logic [$clog2(FRAME_H/DECIM)-1:0]    pixel_y,
    output logic                                frame_start,
    output logic                                frame_done,
    output logic [FCNT_W-1:0]                   frame_count,
    output logic                                line_err
);

    localparam int X_W   = $clog2(FRAME_W / DECIM);
    localparam int Y_W   = $clog2(FRAME_H / DECIM);
    // One extra code so the counters can park at FRAME_W / FRAME_H ("out of window").
    localparam int COL_W = $clog2(FRAME_W + 1);
    localparam int ROW_W = $clog2(FRAME_H + 1);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(FRAME_W);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(FRAME_H);
    localparam logic [COL_W-1:0] COL_DEC = COL_W'(DECIM);
    localparam logic [ROW_W-1:0] ROW_DEC = ROW_W'(DECIM);
    localparam bit               ONE_BYTE = (PIX_BYTES == 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t state, next_state;

    logic vsync_q, href_q;
    logic vs_fall, vs_rise, href_rise, href_fall;
    logic start_evt, done_evt;

    logic             line_active;   // current href line began while ACTIVE
    logic             lines_seen;    // at least one line accepted this frame
    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row;
    logic             phase, cur_phase;
    logic [7:0]       first_byte;
    logic [8*PIX_BYTES-1:0] assembled;

    logic line_start, line_end, take_byte, last_byte, keep, emit;

    assign vs_fall   = vsync_q & ~vsync;
    assign vs_rise   = ~vsync_q & vsync;
    assign href_rise = ~href_q & href;
    assign href_fall = href_q & ~href;

    // Single registered copy of the sync inputs; every edge compares against it.
    always_ff @(posedge p_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
        end
    end

    // Frame state register.
    always_ff @(posedge p_clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic plus the frame start/done events.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (avoids inferred latches).
        next_state = state;
        start_evt  = 1'b0;
        done_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (capture_en) next_state = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    next_state = ACTIVE;
                    start_evt  = 1'b1;
                end
            end
            ACTIVE: begin
                // capture_en is only consulted here, so dropping it never truncates a frame.
                if (vs_rise) begin
                    next_state = capture_en ? WAIT_VS : IDLE;
                    done_evt   = lines_seen;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Byte qualification, pixel completion and the decimation/crop window.
    always_comb begin
        line_start = (state == ACTIVE) && href_rise;
        line_end   = (state == ACTIVE) && href_fall && line_active;
        // Lines whose href rose outside ACTIVE are never captured, even if the frame starts mid-line.
        take_byte  = (state == ACTIVE) && href && (href_rise || line_active);
        cur_col    = href_rise ? '0 : col;
        cur_phase  = href_rise ? 1'b0 : phase;
        last_byte  = ONE_BYTE || cur_phase;
        keep       = (cur_col < COL_MAX) && (row < ROW_MAX) &&
                     ((cur_col % COL_DEC) == '0) && ((row % ROW_DEC) == '0);
        emit       = take_byte && last_byte && keep;
    end

    generate
        if (PIX_BYTES == 2) begin : g_two_byte
            // First byte is the high half unless byte_swap asks for low-first.
            always_comb assembled = byte_swap ? {p_data, first_byte} : {first_byte, p_data};
        end else begin : g_one_byte
            // Single-byte pixels pass straight through.
            always_comb assembled = p_data;
        end
    endgenerate

    // Source column/row counters and line bookkeeping; counters park at the window edge.
    always_ff @(posedge p_clk) begin
        if (reset) begin
            line_active <= 1'b0;
            lines_seen  <= 1'b0;
            col         <= '0;
            row         <= '0;
            phase       <= 1'b0;
            first_byte  <= '0;
        end else begin
            if (start_evt) begin
                row        <= '0;
                lines_seen <= 1'b0;
            end
            if (line_start) begin
                line_active <= 1'b1;
                lines_seen  <= 1'b1;
            end
            if (take_byte) begin
                phase <= ONE_BYTE ? 1'b0 : ~cur_phase;
                if (!cur_phase) first_byte <= p_data;
                if (last_byte) col <= (cur_col == COL_MAX) ? cur_col : cur_col + COL_W'(1);
                else           col <= cur_col;
            end
            // A trailing odd byte is simply forgotten: phase restarts on the next href rise.
            if (line_end) begin
                line_active <= 1'b0;
                if (row != ROW_MAX) row <= row + ROW_W'(1);
            end
            if (next_state != ACTIVE) line_active <= 1'b0;
        end
    end

    // Registered outputs: one-cycle pixel/frame pulses and the completed-frame counter.
    always_ff @(posedge p_clk) begin
        if (reset) begin
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            pixel_valid <= emit;
            frame_start <= start_evt;
            frame_done  <= done_evt;
            if (emit) begin
                pixel_data <= assembled;
                pixel_x    <= X_W'(cur_col / COL_DEC);
                pixel_y    <= Y_W'(row / ROW_DEC);
            end
            if (done_evt) frame_count <= frame_count + FCNT_W'(1);
        end
    end

`ifdef CAM_LINE_CHECK_EN
    // +2 guarantees the saturated count can never alias the expected length.
    localparam int LB_W = $clog2(FRAME_W * PIX_BYTES + 2);
    localparam logic [LB_W-1:0] LINE_BYTES = LB_W'(FRAME_W * PIX_BYTES);

    logic [LB_W-1:0] line_bytes, cur_bytes;

    assign cur_bytes = href_rise ? '0 : line_bytes;

    // Count bytes per accepted line and latch any length mismatch until reset.
    always_ff @(posedge p_clk) begin
        if (reset) begin
            line_bytes <= '0;
            line_err   <= 1'b0;
        end else begin
            if (take_byte && (cur_bytes != '1)) line_bytes <= cur_bytes + LB_W'(1);
            if (line_end && (line_bytes != LINE_BYTES)) line_err <= 1'b1;
        end
    end
`else
    assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_cam_capture_window.sv
// Self-checking bench for cam_capture_window (PIX_BYTES=2, FRAME_W=8, FRAME_H=4, DECIM=2, FCNT_W=2).
module tb_cam_capture_window;

    logic        p_clk = 1'b0;
    logic        reset, capture_en, byte_swap, vsync, href;
    logic [7:0]  p_data;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic [1:0]  pixel_x;
    logic [0:0]  pixel_y;
    logic        frame_start, frame_done;
    logic [1:0]  frame_count;
    logic        line_err;

`ifdef CAM_LINE_CHECK_EN
    localparam logic EXP_LERR = 1'b1;
`else
    localparam logic EXP_LERR = 1'b0;
`endif

    cam_capture_window #(
        .PIX_BYTES(2), .FRAME_W(8), .FRAME_H(4), .DECIM(2), .FCNT_W(2)
    ) dut (
        .p_clk(p_clk), .reset(reset), .capture_en(capture_en), .byte_swap(byte_swap),
        .vsync(vsync), .href(href), .p_data(p_data),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .frame_done(frame_done),
        .frame_count(frame_count), .line_err(line_err)
    );

    always #5 p_clk = ~p_clk;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  x;
        logic        y;
    } pix_t;

    typedef struct {
        logic        ce, bs, vs, hr;
        logic [7:0]  d;
        logic        ev;
        logic [15:0] edata;
        logic [1:0]  ex;
        logic        ey;
        logic        efs;
    } vec_t;

    pix_t q[$];
    int   rd = 0;
    int   done_cnt = 0;
    int   done_base = 0;
    int   total = 0;
    int   bad = 0;

    // Monitor: record every pixel and frame_done pulse at the falling edge.
    always @(negedge p_clk) begin
        if (pixel_valid === 1'b1) q.push_back({pixel_data, pixel_x, pixel_y});
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of bus inputs at negedge, return 1 time unit after the next rising edge.
    task automatic cyc(input logic v, input logic h, input logic [7:0] d);
        @(negedge p_clk);
        vsync  = v;
        href   = h;
        p_data = d;
        @(posedge p_clk);
        #1;
    endtask

    task automatic send_line(input int nb, input int r);
        for (int k = 0; k < nb; k++) cyc(1'b0, 1'b1, 8'(r * 16 + k));
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int nl, input int nb, input int nb0);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        for (int r = 0; r < nl; r++) send_line((r == 0) ? nb0 : nb, r);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
    endtask

    // Expected pixels from the bench's own window/decimation model of a frame.
    task automatic check_pixels(input string tag, input int nl, input int nb, input int nb0);
        int   exp_n = 0;
        int   nbr;
        pix_t p;
        for (int r = 0; r < nl; r++) begin
            nbr = (r == 0) ? nb0 : nb;
            for (int c = 0; 2 * c + 1 < nbr; c++)
                if (c < 8 && r < 4 && c % 2 == 0 && r % 2 == 0) exp_n++;
        end
        check({tag, "_npix"}, q.size() - rd, exp_n);
        for (int r = 0; r < nl; r++) begin
            nbr = (r == 0) ? nb0 : nb;
            for (int c = 0; 2 * c + 1 < nbr; c++) begin
                if (c < 8 && r < 4 && c % 2 == 0 && r % 2 == 0 && rd < q.size()) begin
                    p = q[rd];
                    rd++;
                    check($sformatf("%s_d_r%0d_c%0d", tag, r, c), p.d,
                          {8'(r * 16 + 2 * c), 8'(r * 16 + 2 * c + 1)});
                    check($sformatf("%s_x_r%0d_c%0d", tag, r, c), p.x, c / 2);
                    check($sformatf("%s_y_r%0d_c%0d", tag, r, c), p.y, r / 2);
                end
            end
        end
        rd = q.size();
    endtask

    vec_t tbl[13];

    initial begin
        // {ce, bs, vs, hr, data, exp_valid, exp_data, exp_x, exp_y, exp_frame_start}
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hCD, 1'b1, 16'hABCD, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 16'h4433, 2'd1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};

        reset = 1'b1; capture_en = 1'b0; byte_swap = 1'b0;
        vsync = 1'b0; href = 1'b0; p_data = 8'h00;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("rst_pv", pixel_valid, 0);
        check("rst_pd", pixel_data, 0);
        check("rst_px", pixel_x, 0);
        check("rst_py", pixel_y, 0);
        check("rst_fs", frame_start, 0);
        check("rst_fd", frame_done, 0);
        check("rst_fc", frame_count, 0);
        check("rst_le", line_err, 0);
        reset = 1'b0;

        // Table: arm, vsync fall, one short line with both byte orders.
        for (int i = 0; i < 13; i++) begin
            capture_en = tbl[i].ce;
            byte_swap  = tbl[i].bs;
            cyc(tbl[i].vs, tbl[i].hr, tbl[i].d);
            check($sformatf("vec%0d_pv", i), pixel_valid, tbl[i].ev);
            check($sformatf("vec%0d_fs", i), frame_start, tbl[i].efs);
            if (tbl[i].ev) begin
                check($sformatf("vec%0d_pd", i), pixel_data, tbl[i].edata);
                check($sformatf("vec%0d_px", i), pixel_x, tbl[i].ex);
                check($sformatf("vec%0d_py", i), pixel_y, tbl[i].ey);
            end
        end
        cyc(1'b1, 1'b0, 8'h00);
        check("f1_fd", frame_done, 1);
        check("f1_fc", frame_count, 1);
        cyc(1'b1, 1'b0, 8'h00);
        check("f1_fd_pulse", frame_done, 0);
        rd = q.size();
        done_base = done_cnt;

        // Full 8x4 frame, decimated by 2.
        send_frame(4, 16, 16);
        check_pixels("full", 4, 16, 16);
        check("full_done", done_cnt - done_base, 1);
        check("full_fc", frame_count, 2);
        done_base = done_cnt;

        // capture_en dropped during line 2: frame completes, then capture stops.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        send_line(16, 0);
        for (int k = 0; k < 16; k++) begin
            if (k == 5) capture_en = 1'b0;
            cyc(1'b0, 1'b1, 8'(16 + k));
        end
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        send_line(16, 2);
        send_line(16, 3);
        cyc(1'b1, 1'b0, 8'h00);
        check("cedrop_fd", frame_done, 1);
        cyc(1'b1, 1'b0, 8'h00);
        check_pixels("cedrop", 4, 16, 16);
        check("cedrop_fc", frame_count, 3);
        done_base = done_cnt;
        send_frame(4, 16, 16);
        check_pixels("idle", 0, 16, 16);
        check("idle_done", done_cnt - done_base, 0);
        check("idle_fc", frame_count, 3);

        // Re-arm: counter wraps 3 -> 0 -> 1; oversize frame is cropped.
        capture_en = 1'b1;
        done_base = done_cnt;
        send_frame(4, 16, 16);
        check_pixels("wrap", 4, 16, 16);
        check("wrap_fc0", frame_count, 0);
        send_frame(6, 20, 20);
        check_pixels("crop", 6, 20, 20);
        check("crop_fc1", frame_count, 1);
        check("crop_done", done_cnt - done_base, 2);

        // Reset in the middle of a line.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'(k));
        reset = 1'b1;
        cyc(1'b0, 1'b1, 8'h06);
        check("mid_pre_npix", q.size() - rd, 2);
        rd = q.size();
        check("mid_pv", pixel_valid, 0);
        check("mid_pd", pixel_data, 0);
        check("mid_px", pixel_x, 0);
        check("mid_py", pixel_y, 0);
        check("mid_fs", frame_start, 0);
        check("mid_fd", frame_done, 0);
        check("mid_fc", frame_count, 0);
        check("mid_le", line_err, 0);
        reset = 1'b0;
        done_base = done_cnt;
        for (int k = 7; k < 16; k++) cyc(1'b0, 1'b1, 8'(k));
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        send_line(16, 1);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        check("post_rst_npix", q.size() - rd, 0);
        check("post_rst_done", done_cnt - done_base, 0);
        check("post_rst_fc", frame_count, 0);

        // Capture resumes after the next vsync fall; first line is 15 bytes.
        send_frame(4, 16, 15);
        check_pixels("short", 4, 16, 15);
        check("short_done", done_cnt - done_base, 1);
        check("short_fc", frame_count, 1);
        check("short_le", line_err, EXP_LERR);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        check("short_le_sticky", line_err, EXP_LERR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
